// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants and types
//
// Purpose : constants and the packed IEEE-754 single-precision layout shared
//           by the normalize/round datapath and its helpers.
// Contents: EXP_W, FRAC_W, EXP_BIAS, EXP_MAX, EXP_CALC_W, fp32_t
package fp_pkg;

  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int EXP_BIAS   = 127;
  localparam int EXP_MAX    = 255;
  // Width of the signed exponent used while normalizing, wide enough to hold
  // both an underflowed (negative) and an overflowed (>255) exponent.
  localparam int EXP_CALC_W = 10;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
//
// Purpose : counts leading zeros of data, MSB first; all-zero input gives W.
// Ports   : data  [W-1:0]              value to scan
//           count [$clog2(W+1)-1:0]    number of zeros above the first one
module fp_lzc
  import fp_pkg::*;
#(
  parameter int W = 27
) (
  input  logic [W-1:0]           data,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W + 1);

  // Scan upward from the LSB; the last one seen is the most significant.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - two-stage normalize and round for an FP32 adder result
//
// Purpose : stage1 normalizes the raw adder sum (carry right-shift or
//           leading-zero left-shift), stage2 rounds and packs the FP32 result
//           with overflow / underflow / inexact flags. Valid/ready on both
//           sides, one result per cycle, output held while stalled.
// Build   : FP_NORM_RNE_EN defined   -> round to nearest even
//           FP_NORM_RNE_EN undefined -> truncate toward zero
// Ports   : clk, rst_n (async, active low)
//           in_valid/in_ready, in_sign, in_exp[7:0],
//           in_mant[24+GUARD_W:0] = {carry, hidden, frac[22:0], guard[GUARD_W-1:0]}
//           out_valid/out_ready, out_result[31:0], out_ovf, out_unf, out_inexact
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int GUARD_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic [24+GUARD_W:0] in_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic                out_ovf,
  output logic                out_unf,
  output logic                out_inexact
);

  localparam int MANT_W = 25 + GUARD_W;
  localparam int SIG_W  = MANT_W - 1;            // hidden + fraction + guard
  localparam int LZ_W   = $clog2(SIG_W + 1);
  localparam logic signed [EXP_CALC_W-1:0] EXP_MAX_S = EXP_CALC_W'(EXP_MAX);

  // ---------------- stage1: normalize ----------------
  logic [SIG_W-1:0]             field;
  logic [SIG_W-1:0]             norm_sig;
  logic [LZ_W-1:0]              lz;
  logic signed [EXP_CALC_W-1:0] exp_base;
  logic signed [EXP_CALC_W-1:0] norm_exp;
  logic                         n_zero, n_ovf, n_unf;

  assign field    = in_mant[SIG_W-1:0];
  assign exp_base = $signed({{(EXP_CALC_W-EXP_W){1'b0}}, in_exp});

  fp_lzc #(.W(SIG_W)) u_lzc (
    .data  (field),
    .count (lz)
  );

  always_comb begin
    if (in_mant[MANT_W-1]) begin
      // Carry out of the adder: drop one bit but keep it visible as sticky.
      norm_sig = {in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
      norm_exp = exp_base + EXP_CALC_W'(1);
    end else begin
      norm_sig = field << lz;
      norm_exp = exp_base - $signed({{(EXP_CALC_W-LZ_W){1'b0}}, lz});
    end
    // After normalizing, the hidden position is empty only for a zero sum.
    n_zero = !norm_sig[SIG_W-1];
    n_ovf  = !n_zero && ((in_exp == EXP_W'(EXP_MAX)) || (norm_exp >= EXP_MAX_S));
    n_unf  = !n_zero && !n_ovf && (norm_exp <= EXP_CALC_W'(0));
  end

  logic             s1_valid, s1_sign, s1_zero, s1_ovf, s1_unf;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_sig;
  logic             s1_adv;

  assign s1_adv   = !out_valid || out_ready;
  // Held low while in reset so nothing is taken before the pipe is cleared.
  assign in_ready = rst_n && (!s1_valid || s1_adv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_unf   <= 1'b0;
      s1_exp   <= '0;
      s1_sig   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_zero <= n_zero;
        s1_ovf  <= n_ovf;
        s1_unf  <= n_unf;
        s1_exp  <= norm_exp[EXP_W-1:0];
        s1_sig  <= norm_sig;
      end
    end
  end

  // ---------------- stage2: round and pack ----------------
  logic [FRAC_W-1:0]  frac;
  logic [GUARD_W-1:0] grs;
  logic               round_up;
  logic [FRAC_W:0]    frac_sum;
  logic [EXP_W:0]     exp_sum;
  fp32_t              res;
  logic               res_ovf, res_unf, res_inexact;

  assign frac = s1_sig[GUARD_W +: FRAC_W];
  assign grs  = s1_sig[GUARD_W-1:0];

  always_comb begin
`ifdef FP_NORM_RNE_EN
    round_up = grs[GUARD_W-1] & ((|grs[GUARD_W-2:0]) | frac[0]);
`else
    round_up = 1'b0;
`endif
    frac_sum = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
    // A carry out of the fraction leaves it at zero and bumps the exponent.
    exp_sum  = {1'b0, s1_exp} + {{EXP_W{1'b0}}, frac_sum[FRAC_W]};

    res         = '0;
    res_ovf     = 1'b0;
    res_unf     = 1'b0;
    res_inexact = 1'b0;
    if (s1_zero) begin
      res = '0;
    end else if (s1_ovf) begin
      res         = '{sign: s1_sign, exp: '1, frac: '0};
      res_ovf     = 1'b1;
      res_inexact = 1'b1;
    end else if (s1_unf) begin
      // Flushed nonzero value: signed zero, counted as inexact.
      res         = '{sign: s1_sign, exp: '0, frac: '0};
      res_unf     = 1'b1;
      res_inexact = 1'b1;
    end else if (exp_sum >= (EXP_W+1)'(EXP_MAX)) begin
      res         = '{sign: s1_sign, exp: '1, frac: '0};
      res_ovf     = 1'b1;
      res_inexact = 1'b1;
    end else begin
      res         = '{sign: s1_sign, exp: exp_sum[EXP_W-1:0], frac: frac_sum[FRAC_W-1:0]};
      res_inexact = |grs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= res;
        out_ovf     <= res_ovf;
        out_unf     <= res_unf;
        out_inexact <= res_inexact;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - self-checking bench for fp_norm_round
module tb_fp_norm_round;

  localparam int G = 3;
  localparam int M = 25 + G;
  localparam int H = G + 23;   // hidden bit position in in_mant
`ifdef FP_NORM_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_sign;
  logic [7:0]   in_exp;
  logic [M-1:0] in_mant;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_result;
  logic         out_ovf, out_unf, out_inexact;

  fp_norm_round #(.GUARD_W(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        inx;
  } res_t;

  typedef struct {
    string        name;
    logic         sign;
    logic [7:0]   exp;
    logic [M-1:0] mant;
    res_t         want;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];
  res_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: value-level normalize and round from the format rules.
  function automatic res_t model(input logic s, input int e_in, input longint m);
    res_t   r;
    int     p, sh, e;
    longint sig, q, rem, half;
    r = '0;
    if (m == 0) return r;
    if (e_in == 255) begin
      r.result = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; r.inx = 1'b1;
      return r;
    end
    p = 0;
    for (int i = 0; i < M; i++) if (m[i]) p = i;
    sh = p - H;
    e  = e_in + sh;
    if (sh > 0) sig = (m >> 1) | (m & 1);
    else        sig = m << (-sh);
    if (e >= 255) begin
      r.result = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; r.inx = 1'b1;
      return r;
    end
    if (e <= 0) begin
      r.result = {s, 31'd0}; r.unf = 1'b1; r.inx = 1'b1;
      return r;
    end
    half = longint'(1) << (G - 1);
    q    = sig >> G;
    rem  = sig & ((longint'(1) << G) - 1);
    if (RNE && (rem > half || (rem == half && q[0]))) q = q + 1;
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      r.result = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; r.inx = 1'b1;
      return r;
    end
    r.result = {s, e[7:0], q[22:0]};
    r.inx    = (rem != 0);
    return r;
  endfunction

  // Scoreboard: every accepted input must leave once, in order, matching the model.
  always @(negedge clk) begin
    res_t exp_r;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected: got %h, expected no output", out_result);
        end else begin
          exp_r = sb_q.pop_front();
          check("sb_result", {out_result, out_ovf, out_unf, out_inexact}, exp_r);
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(in_sign, int'(in_exp), longint'(in_mant)));
    end
  end

  task automatic add_vec(input string n, input logic s, input int e, input longint m,
                         input logic [31:0] r, input logic ov, input logic un, input logic ix);
    vec_t v;
    v.name = n; v.sign = s; v.exp = 8'(e); v.mant = m[M-1:0];
    v.want = '{result: r, ovf: ov, unf: un, inx: ix};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [M-1:0] m);
    in_sign = s; in_exp = e; in_mant = m;
  endtask

  task automatic rand_input();
    int     edges[6] = '{0, 1, 2, 253, 254, 255};
    int     p, r;
    longint m, bits;
    in_sign = 1'($urandom % 2);
    if ($urandom % 8 == 0) in_exp = 8'(edges[$urandom % 6]);
    else                   in_exp = 8'($urandom_range(1, 254));
    r = int'($urandom % 16);
    if (r == 0) begin
      m = 0;
    end else begin
      p    = int'($urandom_range(0, M - 1));
      bits = {$urandom, $urandom};
      m    = (longint'(1) << p) | (bits & ((longint'(1) << p) - 1));
      if (r == 1 && p >= G)
        m = (m & ~((longint'(1) << G) - 1)) | (longint'(1) << (G - 1));
    end
    in_mant = m[M-1:0];
  endtask

  longint one_h, frac_ones, half_g;
  int     cyc, k, got, stall_bad, stall_seen, spurious, sent;
  logic   fire;
  logic         bp_s[4];
  logic [7:0]   bp_e[4];
  logic [M-1:0] bp_m[4];
  res_t         bp_w[4];

  initial begin
    one_h     = longint'(1) << H;
    frac_ones = longint'(23'h7FFFFF) << G;
    half_g    = longint'(1) << (G - 1);

    add_vec("exact",        0, 127, one_h,                         32'h3F800000, 0, 0, 0);
    add_vec("carry",        0, 127, one_h << 1,                    32'h40000000, 0, 0, 0);
    add_vec("carry_sticky", 0, 127, (one_h << 1) | 1,              32'h40000000, 0, 0, 1);
    add_vec("lshift2",      0, 130, one_h >> 2,                    32'h40000000, 0, 0, 0);
    add_vec("tie_even",     0, 127, one_h | half_g,                32'h3F800000, 0, 0, 1);
`ifdef FP_NORM_RNE_EN
    add_vec("tie_odd",      0, 127, one_h | frac_ones | half_g,    32'h40000000, 0, 0, 1);
    add_vec("above_half",   0, 127, one_h | half_g | 1,            32'h3F800001, 0, 0, 1);
    add_vec("round_ovf",    0, 254, one_h | frac_ones | 7,         32'h7F800000, 1, 0, 1);
`else
    add_vec("tie_odd",      0, 127, one_h | frac_ones | half_g,    32'h3FFFFFFF, 0, 0, 1);
    add_vec("above_half",   0, 127, one_h | half_g | 1,            32'h3F800000, 0, 0, 1);
    add_vec("round_ovf",    0, 254, one_h | frac_ones | 7,         32'h7F7FFFFF, 0, 0, 1);
`endif
    add_vec("ovf_pos",      0, 254, one_h << 1,                    32'h7F800000, 1, 0, 1);
    add_vec("ovf_neg",      1, 254, one_h << 1,                    32'hFF800000, 1, 0, 1);
    add_vec("exp255",       0, 255, one_h,                         32'h7F800000, 1, 0, 1);
    add_vec("unf",          0, 3,   one_h >> 5,                    32'h00000000, 0, 1, 1);
    add_vec("unf_neg",      1, 1,   one_h >> 1,                    32'h80000000, 0, 1, 1);
    add_vec("min_norm",     0, 1,   one_h,                         32'h00800000, 0, 0, 0);
    add_vec("zero",         0, 100, 0,                             32'h00000000, 0, 0, 0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 8'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bundle", {out_result, out_ovf, out_unf, out_inexact}, 0);
    check("rst_in_ready", in_ready, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);

    // Directed table: single transfers, latency and value.
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      drive(tbl[i].sign, tbl[i].exp, tbl[i].mant);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 8) begin
        @(posedge clk); #1;
        cyc++;
      end
      check({tbl[i].name, "_lat"}, cyc, 2);
      check(tbl[i].name, {out_result, out_ovf, out_unf, out_inexact}, tbl[i].want);
      @(posedge clk); #1;
    end

    // Backpressure: 4 back-to-back inputs against a 6-cycle output stall.
    for (int i = 0; i < 4; i++) begin
      bp_s[i] = 1'(i % 2);
      bp_e[i] = 8'(100 + 10 * i);
      bp_m[i] = M'((one_h >> i) | longint'(i * 5 + 1));
      bp_w[i] = model(bp_s[i], int'(bp_e[i]), longint'(bp_m[i]));
    end
    out_ready = 1'b0; k = 0; stall_bad = 0; stall_seen = 0;
    in_valid = 1'b1; drive(bp_s[0], bp_e[0], bp_m[0]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      if (out_valid) begin
        stall_seen++;
        if ({out_result, out_ovf, out_unf, out_inexact} !== bp_w[0]) stall_bad++;
      end
      @(posedge clk); #1;
      if (fire) begin
        k++;
        if (k < 4) drive(bp_s[k], bp_e[k], bp_m[k]);
        else in_valid = 1'b0;
      end
    end
    check("bp_accepted_before_stall", k, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_stall_cycles", stall_seen, 4);
    check("bp_stall_stable", stall_bad, 0);
    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("bp_order%0d", got), {out_result, out_ovf, out_unf, out_inexact}, bp_w[got]);
        got++;
      end
      @(posedge clk); #1;
      if (fire) begin
        k++;
        if (k < 4) drive(bp_s[k], bp_e[k], bp_m[k]);
        else in_valid = 1'b0;
      end
    end
    check("bp_all_out", got, 4);

    // Reset pulse mid-stream: in-flight results must vanish.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_input();
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_bundle", {out_result, out_ovf, out_unf, out_inexact}, 0);
    check("midrst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("midrst_in_ready_after", in_ready, 1);
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("midrst_no_output", spurious, 0);

    // Randomized traffic with random backpressure against the model.
    sent = 0; cyc = 0; in_valid = 1'b0;
    @(posedge clk); #1;
    while (sent < 400 && cyc < 20000) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (fire) sent++;
      if (!in_valid || fire) begin
        if (sent < 400 && ($urandom % 4) != 0) begin
          in_valid = 1'b1;
          rand_input();
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = (($urandom % 3) != 0);
    end
    check("rand_sent", sent, 400);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    check("drain_empty", sb_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 Parameter GUARD_W, default 3: number of guard/round/sticky bits below the fraction LSB; legal range 2..8; the LSB of the group is sticky.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream adder result valid.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 in_sign  input  1  sign of raw sum.
REQ-007 in_exp  input  8  biased exponent of the larger operand (max exponent).
REQ-008 in_mant  input  25+GUARD_W  raw sum, fields from MSB down:
- carry bit
- hidden bit
- 23-bit fraction
- GUARD_W guard bits
REQ-009 out_valid  output  1  packed result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_result  output  32  IEEE-754 single-precision result.
REQ-012 out_ovf  output  1  result saturated to infinity.
REQ-013 out_unf  output  1  result flushed to zero.
REQ-014 out_inexact  output  1  nonzero bits were discarded during rounding.

Function
REQ-015 Transfer occurs on a cycle where valid and ready are both high, on each side.
REQ-016 Two-stage pipeline; with out_ready held high, a result appears on out_valid exactly 2 cycles after its input transfer.
REQ-017 Throughput is one result per cycle with no bubbles while out_ready is high.
REQ-018 in_ready = NOT stage1_valid OR stage1 advancing; stage1 advances when stage2 is empty or stage2 is transferring.
REQ-019 While out_valid is high and out_ready is low, out_* are held stable.
REQ-020 Results leave in arrival order; none are dropped or duplicated.
REQ-021 Stage1 (normalize), carry=1: shift right 1, OR the dropped bit into sticky, exponent+1.
REQ-022 Stage1 (normalize), carry=0: left-shift by the leading-zero count of the hidden+fraction+guard field, exponent minus the count.
REQ-023 Stage1 arithmetic uses 10-bit signed exponent arithmetic.
REQ-024 in_mant all zero -> result +0 (0x00000000); out_unf=0; out_inexact=0.
REQ-025 Normalized exponent <= 0 -> result signed zero; out_unf=1; no subnormals are produced.
REQ-026 Stage2 (round) applies the mode from REQ-035 to the 23-bit fraction.
REQ-027 If rounding carries out of the fraction, the fraction becomes 0 and the exponent increments by 1.
REQ-028 Exponent >= 255 after normalize or round -> {sign, 0xFF, 0}; out_ovf=1; out_inexact=1.
REQ-029 in_exp = 255 on input is treated as overflow per REQ-028.
REQ-030 out_ovf, out_unf and out_inexact are valid only with out_valid and are registered alongside out_result.

Reset
REQ-031 Reset clears both stages: out_valid=0, out_result=0, out_ovf=0, out_unf=0, out_inexact=0.
REQ-032 During reset, in_ready=0; it is 1 on the first cycle after deassertion.
REQ-033 Reset asserted mid-operation discards all in-flight results; no partial output follows.

Configuration
REQ-034 Macro FP_NORM_RNE_EN selects the rounding mode.
REQ-035 When FP_NORM_RNE_EN is defined, rounding is round-to-nearest-even:
- round up if guard=1 and (round|sticky|lsb)=1
REQ-036 When FP_NORM_RNE_EN is undefined, rounding is truncation toward zero; out_inexact is still reported.

Structure
REQ-037 Shared package fp_pkg holds:
- EXP_W=8, FRAC_W=23, EXP_BIAS=127, EXP_MAX=255
- typedef fp32_t {sign, exp, frac}
REQ-038 Leading-zero count is a separate sub-module fp_lzc, parameterized on input width, combinational, used in stage1.

Verification
REQ-039 Exact value: sign0, exp127, mant hidden=1, rest 0 -> 0x3F800000 two cycles later; inexact=0.
REQ-040 Carry normalize: exp127, carry=1, rest 0 -> 0x40000000.
REQ-041 Tie case: exp127, hidden=1, fraction all ones, guard=100b:
- RNE build -> 0x40000000, inexact=1
- truncate build -> 0x3FFFFFFF, inexact=1
REQ-042 Overflow: exp254, carry=1 -> 0x7F800000, out_ovf=1; with sign1 -> 0xFF800000.
REQ-043 Underflow: exp3, leading one 5 places below hidden -> 0x00000000, out_unf=1.
REQ-044 Backpressure: 4 back-to-back inputs, out_ready low 6 cycles then high:
- in_ready falls after 2 accepted
- out_result stable while stalled
- all 4 emerge in order
- rst_n pulse mid-stream empties the pipe
